acr_packet_receiver: RTL

Sink-side counterpart of the HDMI Audio Clock Regeneration (ACR) packet generator (HDMI 1.4b §5.3.3, §7.2.3). The block runs in the pixel clock domain behind the data-island packet decoder. It validates incoming ACR packets, extracts N and CTS, and runs a lock state machine. While locked, it regenerates 128·fs and fs clock-enable strobes from the pixel clock with an N/CTS fractional accumulator.

---
 rtl/acr_packet_receiver.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/acr_packet_receiver.sv
// HDMI ACR packet receiver: validates ACR packets, holds N/CTS, tracks lock and
// regenerates 128*fs / fs clock-enable strobes with an N/CTS fractional accumulator.
module acr_packet_receiver #(
    parameter int LOCK_COUNT     = 3,
    parameter int CTS_TOLERANCE  = 2,
    parameter int TIMEOUT_CYCLES = 262144
) (
    input  logic         clk_pixel,
    input  logic         reset,
    input  logic         packet_valid,
    input  logic [23:0]  header,
    input  logic [223:0] sub,
    output logic [19:0]  n_value,
    output logic [19:0]  cts_value,
    output logic         locked,
    output logic         audio_tick,
    output logic         sample_tick,
    output logic         packet_error,
    output logic [7:0]   error_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE = TW'(1);
    localparam logic [7:0] LOCK_TARGET = 8'(LOCK_COUNT);
    localparam logic signed [20:0] TOL = 21'(CTS_TOLERANCE);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    function automatic logic signed [20:0] abs21(input logic signed [20:0] v);
        return (v < 0) ? -v : v;
    endfunction

    state_t       state_q, state_d;
    logic [7:0]   match_q, match_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic [19:0]  n_value_q, n_value_d;
    logic [19:0]  cts_value_q, cts_value_d;
    logic [20:0]  acc_q, acc_d;
    logic [6:0]   div_q, div_d;
    logic         locked_q, locked_d;
    logic         audio_tick_q, audio_tick_d;
    logic         sample_tick_q, sample_tick_d;
    logic         packet_error_q, packet_error_d;
    logic [7:0]   error_count_q, error_count_d;

    logic [55:0]  sp0;
    logic [19:0]  pkt_n, pkt_cts;
    logic         is_acr, same_sp, rsvd_zero, well_formed;
    logic         accepted, rejected, consistent;
    logic signed [20:0] cts_diff;
    logic [20:0]  acc_sum;
    logic [7:0]   match_inc;
    logic         unused_hdr;

    assign unused_hdr = ^header[23:8];

    // Subpacket 0 is the reference; the other three must match it exactly.
    assign sp0       = sub[55:0];
    assign pkt_n     = {sp0[35:32], sp0[47:40], sp0[55:48]};
    assign pkt_cts   = {sp0[11:8], sp0[23:16], sp0[31:24]};
    assign is_acr    = packet_valid && (header[7:0] == 8'h01);
    assign same_sp   = (sub[111:56] == sp0) && (sub[167:112] == sp0) && (sub[223:168] == sp0);
    assign rsvd_zero = (sp0[39:36] == 4'h0) && (sp0[15:12] == 4'h0) && (sp0[7:0] == 8'h00);
    assign well_formed = same_sp && rsvd_zero && (pkt_n != 20'd0) && (pkt_cts != 20'd0)
                         && (pkt_n < pkt_cts);
    assign accepted  = is_acr && well_formed;
    assign rejected  = is_acr && !well_formed;
    assign cts_diff  = $signed({1'b0, pkt_cts}) - $signed({1'b0, cts_value_q});
    assign consistent = (pkt_n == n_value_q) && (abs21(cts_diff) <= TOL);
    assign acc_sum   = acc_q + {1'b0, n_value_q};
    assign match_inc = match_q + 8'd1;

    always_comb begin
        state_d        = state_q;
        match_d        = match_q;
        timeout_d      = timeout_q;
        n_value_d      = n_value_q;
        cts_value_d    = cts_value_q;
        packet_error_d = rejected;
        error_count_d  = error_count_q;
        acc_d          = 21'd0;
        div_d          = 7'd0;
        audio_tick_d   = 1'b0;
        sample_tick_d  = 1'b0;

        if (rejected && (error_count_q != 8'hFF)) begin
            error_count_d = error_count_q + 8'd1;
        end

        // An accepted packet always beats the timeout in the same cycle.
        if (accepted) begin
            n_value_d   = pkt_n;
            cts_value_d = pkt_cts;
            timeout_d   = '0;
            case (state_q)
                ST_UNLOCKED: begin
                    match_d = 8'd1;
                    state_d = (LOCK_COUNT <= 1) ? ST_LOCKED : ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (consistent) begin
                        match_d = match_inc;
                        if (match_inc >= LOCK_TARGET) state_d = ST_LOCKED;
                    end else begin
                        match_d = 8'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!consistent) begin
                        match_d = 8'd1;
                        state_d = ST_ACQUIRE;
                    end
                end
                default: begin
                    match_d = 8'd1;
                    state_d = ST_ACQUIRE;
                end
            endcase
        end else if (timeout_q == TO_LAST) begin
            timeout_d = '0;
            state_d   = ST_UNLOCKED;
        end else begin
            timeout_d = timeout_q + TO_ONE;
        end

        // The step uses the held N/CTS; leaving LOCKED squashes the tick and clears acc.
        if ((state_q == ST_LOCKED) && (state_d == ST_LOCKED)) begin
            if (acc_sum >= {1'b0, cts_value_q}) begin
                acc_d         = acc_sum - {1'b0, cts_value_q};
                audio_tick_d  = 1'b1;
                div_d         = div_q + 7'd1;
                sample_tick_d = (div_q == 7'd127);
            end else begin
                acc_d = acc_sum;
                div_d = div_q;
            end
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q        <= ST_UNLOCKED;
            match_q        <= 8'd0;
            timeout_q      <= '0;
            n_value_q      <= 20'd0;
            cts_value_q    <= 20'd0;
            acc_q          <= 21'd0;
            div_q          <= 7'd0;
            locked_q       <= 1'b0;
            audio_tick_q   <= 1'b0;
            sample_tick_q  <= 1'b0;
            packet_error_q <= 1'b0;
            error_count_q  <= 8'd0;
        end else begin
            state_q        <= state_d;
            match_q        <= match_d;
            timeout_q      <= timeout_d;
            n_value_q      <= n_value_d;
            cts_value_q    <= cts_value_d;
            acc_q          <= acc_d;
            div_q          <= div_d;
            locked_q       <= locked_d;
            audio_tick_q   <= audio_tick_d;
            sample_tick_q  <= sample_tick_d;
            packet_error_q <= packet_error_d;
            error_count_q  <= error_count_d;
        end
    end

    assign n_value      = n_value_q;
    assign cts_value    = cts_value_q;
    assign locked       = locked_q;
    assign audio_tick   = audio_tick_q;
    assign sample_tick  = sample_tick_q;
    assign packet_error = packet_error_q;
    assign error_count  = error_count_q;

endmodule
